// File: rtl/scmp_microcode_pak.sv
// Shared types for the SC/MP microcode sequencer: fetch FSM states and the
// next-address selection used by the opcode fetch unit.
package scmp_microcode_pak;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OP    = 2'd1,
    S_DISP  = 2'd2,
    S_VALID = 2'd3
  } FETCH_STATE_t;

  // Source for the next value of the fetch address register.
  typedef enum logic [1:0] {
    NPC_HOLD    = 2'd0,
    NPC_FROM_PC = 2'd1,
    NPC_STEP    = 2'd2
  } NEXTPC_t;

endpackage

// File: rtl/scmp_pc_inc.sv
// SC/MP page-wrapping incrementer: the low 16-PAGE_BITS bits count and wrap,
// the page bits pass through untouched.
module scmp_pc_inc #(
  parameter int PAGE_BITS = 4
) (
  input  logic [15:0] a,
  output logic [15:0] y
);

  localparam int LW = 16 - PAGE_BITS;

  logic [LW-1:0] low;

  assign low = a[LW-1:0] + LW'(1);
  assign y   = {a[15:LW], low};

endmodule

// File: rtl/scmp_opfetch.sv
// SC/MP opcode/displacement fetch unit: pre-increments P0, reads the opcode
// and, for bit7-set opcodes, a displacement byte, then holds both for the decoder.
module scmp_opfetch
  import scmp_microcode_pak::*;
#(
  parameter int PAGE_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [15:0] pc,
  output logic        pc_wr,
  output logic [15:0] pc_wdata,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  ir,
  output logic [7:0]  disp,
  output logic        ir_valid,
  input  logic        ir_take,
  output logic        busy
);

  FETCH_STATE_t state, state_nx;
  NEXTPC_t      npc_sel;
  logic [15:0]  addr_r, pc_inc, addr_inc;
  logic         ir_ld, disp_ld, disp_clr, wr_nx;

  scmp_pc_inc #(.PAGE_BITS(PAGE_BITS)) u_pc_inc   (.a(pc),     .y(pc_inc));
  scmp_pc_inc #(.PAGE_BITS(PAGE_BITS)) u_addr_inc (.a(addr_r), .y(addr_inc));

  assign bus_addr = addr_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    npc_sel  = NPC_HOLD;
    ir_ld    = 1'b0;
    disp_ld  = 1'b0;
    disp_clr = 1'b0;
    wr_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_start) begin
          state_nx = S_OP;
          npc_sel  = NPC_FROM_PC;
        end
      end
      S_OP: begin
        if (bus_ack) begin
          ir_ld   = 1'b1;
          wr_nx   = 1'b1;
          npc_sel = NPC_STEP;
          if (bus_rdata[7]) begin
            state_nx = S_DISP;
          end else begin
            state_nx = S_VALID;
            disp_clr = 1'b1;
          end
        end
      end
      S_DISP: begin
        if (bus_ack) begin
          disp_ld  = 1'b1;
          wr_nx    = 1'b1;
          state_nx = S_VALID;
        end
      end
      S_VALID: begin
        // Taking the instruction and starting the next one in the same cycle
        // skips S_IDLE entirely.
        if (ir_take) begin
          if (fetch_start) begin
            state_nx = S_OP;
            npc_sel  = NPC_FROM_PC;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r   <= 16'h0000;
      ir       <= 8'h00;
      disp     <= 8'h00;
      pc_wr    <= 1'b0;
      pc_wdata <= 16'h0000;
      bus_req  <= 1'b0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (npc_sel)
        NPC_FROM_PC: addr_r <= pc_inc;
        NPC_STEP:    addr_r <= addr_inc;
        default:     addr_r <= addr_r;
      endcase
      if (ir_ld)   ir   <= bus_rdata;
      if (disp_ld) disp <= bus_rdata;
      else if (disp_clr) disp <= 8'h00;
      pc_wr <= wr_nx;
      if (wr_nx) pc_wdata <= addr_r;
      bus_req  <= (state_nx == S_OP) || (state_nx == S_DISP);
      ir_valid <= (state_nx == S_VALID);
      busy     <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: doc/scmp_opfetch.md
SCMP_OPFETCH -- requirements
Module: scmp_opfetch

Interface
REQ-001 SHALL have parameter PAGE_BITS, default 4: upper PC bits held constant on increment. The lower 16-PAGE_BITS bits wrap within the page.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port fetch_start, input, 1, sequencer request to fetch the next instruction.
REQ-005 SHALL have port pc, input, 16, current P0 value, sampled on accepted fetch_start.
REQ-006 SHALL have port pc_wr, output, 1, one-cycle strobe to write P0.
REQ-007 SHALL have port pc_wdata, output, 16, new P0 value, valid when pc_wr=1.
REQ-008 SHALL have port bus_req, output, 1, memory read request.
REQ-009 SHALL have port bus_addr, output, 16, read address.
REQ-010 SHALL have port bus_ack, input, 1, read data valid this cycle.
REQ-011 SHALL have port bus_rdata, input, 8, read data.
REQ-012 SHALL have port ir, output, 8, latched opcode; this is the op input of the microcode entry-point decoder.
REQ-013 SHALL have port disp, output, 8, latched second byte; 0x00 for one-byte instructions.
REQ-014 SHALL have port ir_valid, output, 1, ir/disp complete and held.
REQ-015 SHALL have port ir_take, input, 1, consumer accepts ir/disp.
REQ-016 SHALL have port busy, output, 1, high in every state except S_IDLE.

Function
REQ-017 SHALL implement the FSM states S_IDLE, S_OP, S_DISP and S_VALID.
REQ-018 Increment SHALL be inc(a) = {a[15:16-PAGE_BITS], a[15-PAGE_BITS:0]+1}, with no carry into the page bits.
REQ-019 In S_IDLE, fetch_start=1 SHALL load addr_r <= inc(pc) and go to S_OP; bus_req SHALL rise exactly one cycle after fetch_start.
REQ-020 In S_OP/S_DISP, bus_req SHALL be 1 and bus_addr=addr_r, both held stable until a cycle with bus_ack=1.
REQ-021 In S_OP with bus_ack=1, the block SHALL set ir <= bus_rdata, pulse pc_wr with pc_wdata=addr_r, and set addr_r <= inc(addr_r). The next state SHALL be S_DISP if bus_rdata[7]=1, else S_VALID with disp <= 0x00.
REQ-022 In S_DISP with bus_ack=1, the block SHALL set disp <= bus_rdata, pulse pc_wr with pc_wdata=addr_r, and go to S_VALID.
REQ-023 bus_ack SHALL be ignored in S_IDLE and S_VALID.
REQ-024 ir_valid SHALL be 1 only in S_VALID, and ir/disp SHALL be stable throughout S_VALID.
REQ-025 In S_VALID, ir_take=1 SHALL go to S_IDLE. If fetch_start=1 in the same cycle, the block SHALL go directly to S_OP with addr_r <= inc(pc), giving back-to-back fetch with no idle cycle.
REQ-026 fetch_start SHALL be ignored in S_OP and S_DISP.
REQ-027 pc_wr SHALL pulse exactly once per fetched byte; minimum latency from fetch_start to ir_valid is 3 cycles for one-byte and 4 cycles for two-byte instructions, with zero-wait ack.
REQ-028 ir_take SHALL be ignored when ir_valid=0.

Reset
REQ-029 While rst=1, the block SHALL force state=S_IDLE, addr_r=0x0000, ir=0x00, disp=0x00, pc_wr=0, pc_wdata=0x0000, bus_req=0, bus_addr=0x0000, ir_valid=0, busy=0.
REQ-030 rst asserted mid-fetch SHALL drop bus_req asynchronously. A pending bus_ack after reset release SHALL be ignored.

Structure
REQ-031 FETCH_STATE_t (the enum of the four states) SHALL live in scmp_microcode_pak alongside NEXTPC_t.
REQ-032 The page-wrap incrementer SHALL be a combinational sub-module scmp_pc_inc, parameterised by PAGE_BITS, and instantiated twice (pc path, addr_r path).
REQ-033 All outputs SHALL be registered except bus_addr, which SHALL be driven directly from addr_r.

Verification
REQ-034 One-byte: pc=0x1234, fetch_start, ack rdata=0x08 -> bus_addr=0x1235, pc_wr pc_wdata=0x1235, ir=0x08, disp=0x00, ir_valid at cycle 3.
REQ-035 Two-byte: pc=0x2010, rdata 0xC4 then 0x5A -> addresses 0x2011 then 0x2012, two pc_wr pulses, ir=0xC4, disp=0x5A, ir_valid at cycle 4.
REQ-036 Page wrap: pc=0x3FFF, PAGE_BITS=4, two-byte op -> addresses 0x3000 then 0x3001, with no carry into page bits.
REQ-037 Wait states: ack delayed 5 cycles -> bus_req/bus_addr stable throughout; no pc_wr until ack.
REQ-038 Back-to-back: ir_take and fetch_start in the same S_VALID cycle -> bus_req=1 next cycle with no S_IDLE cycle; a spurious bus_ack in S_VALID does not change ir.
REQ-039 Reset mid S_DISP: rst pulse -> all outputs at reset values immediately; a later ack causes no pc_wr.
